bram_port_responder: RTL
========================

Name: bram_port_responder

Overview:
- Synthesizable single-port block-RAM responder sitting on the far side of the NPU RAM port: it receives rst/en/we/addr/data exactly as the RAM reader and writer engines drive them, and returns read data.
- Serves as the on-chip image/filter/result buffer in standalone builds and as the cycle-accurate memory for NPU regression benches.
- Adds read-valid, address-error and access-count sideband outputs for verification.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words.
- READ_LATENCY, 1, edges from read request to data on o_ram_data; legal values 1 or 2.
- WRITE_FIRST, 0, 0 = read-first (old word returned on a write), 1 = write-first (merged new word returned).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high block reset.
- i_rst_ram  in  1  BRAM output-latch reset, synchronous, active-high.
- i_en_ram  in  1  port enable.
- i_wr_ram  in  WIDTH/8  byte write enables.
- i_ram_addr  in  32  byte address; bits [1:0] ignored.
- i_ram_data  in  WIDTH  write data.
- o_ram_data  out  WIDTH  read data.
- o_rd_valid  out  1  high in the cycle o_ram_data carries the result of a read.
- o_addr_err  out  1  one-cycle pulse on an out-of-range access.
- o_rd_count  out  16  in-range reads accepted, saturating.
- o_wr_count  out  16  in-range writes committed, saturating.

Behaviour:
- Word index = i_ram_addr >> 2. An access is in range when the index < DEPTH.
- Array contents are initialised to 0 at configuration. Neither i_reset nor i_rst_ram clears the array.
- A request is sampled at a rising edge with i_en_ram = 1.
  - Read: i_wr_ram = 0.
  - Write: any bit of i_wr_ram set. Byte lane k (bits 8k+7:8k) is updated only where i_wr_ram[k] = 1; other lanes keep their value.
- Stage 1 output register:
  - Loads only on enabled edges; otherwise holds.
  - Read: loads mem[idx].
  - Write: loads the pre-write word (WRITE_FIRST = 0) or the merged word (WRITE_FIRST = 1).
  - Out-of-range access: loads 0.
- READ_LATENCY = 1: o_ram_data is the stage 1 register, so data is visible the cycle after the request edge.
- READ_LATENCY = 2: a stage 2 register copies stage 1 every edge, adding one cycle.
- o_rd_valid:
  - en & ~|wr & in-range, delayed by READ_LATENCY edges.
  - Back-to-back reads give continuous valid with one word per cycle.
  - Writes never assert o_rd_valid.
- Out-of-range access:
  - No array update, and counters are unchanged.
  - o_addr_err = 1 for exactly the cycle after the request edge.
  - o_rd_valid is not asserted for it.
- i_rst_ram = 1 at an edge:
  - Stage 1, stage 2 and the valid pipeline clear to 0 at that edge; o_ram_data = 0 and o_rd_valid = 0 the next cycle.
  - A read sampled at the same edge is discarded (not counted).
  - A write sampled at the same edge still commits and is counted.
- i_reset = 1 at an edge has priority over everything:
  - o_ram_data, o_rd_valid, o_addr_err and both counters go to 0.
  - In-flight reads are dropped; any request at that edge is ignored, including writes.
  - All outputs read 0 the cycle after reset is applied.
- Counters saturate at 16'hFFFF and do not wrap.
- Simultaneous read/write: not possible on a single port; a request with any wr bit set is a write.

Test Plan:
- Reset and latency: i_reset for 2 cycles.
  - All outputs must read 0.
  - Write 32'hDEADBEEF to addr 0x10 (wr = 4'hF), then read 0x10.
  - With READ_LATENCY = 1, o_ram_data = 32'hDEADBEEF with o_rd_valid = 1 one cycle after the read edge; with READ_LATENCY = 2, two cycles after.
  - o_wr_count = 1, o_rd_count = 1.
- Byte lanes: write 32'h11223344 to 0x20, then write 32'hAABBCCDD with wr = 4'b0101, then read 0x20 -> 32'h11BB33DD.
- Read/write-first, repeating the write 32'hAABBCCDD (wr = 4'b0101) to a word holding 32'h11223344:
  - WRITE_FIRST = 0 -> o_ram_data = 32'h11223344 after the write, o_rd_valid = 0.
  - WRITE_FIRST = 1 -> 32'h11BB33DD.
- Streaming with output reset:
  - Read addresses 0x0, 0x4, 0x8, 0xC back-to-back -> four consecutive valid words in order.
  - i_rst_ram asserted on the third read edge -> that word is lost (o_ram_data = 0, valid = 0), the fourth word returns normally, o_rd_count = 3.
- Out of range (DEPTH = 1024):
  - Write to 0x1000 -> o_addr_err pulses 1 cycle, o_wr_count unchanged.
  - Then read 0x1000 -> o_ram_data = 0, o_rd_valid = 0, o_addr_err pulse.
  - Then read 0x0FFC -> normal data.
- Reset mid-stream and saturation:
  - Assert i_reset with two reads in flight (READ_LATENCY = 2) -> no o_rd_valid afterwards; the array retains 32'hDEADBEEF at 0x10.
  - Issue 65,540 reads -> o_rd_count holds at 16'hFFFF.

Source files
------------

// File: rtl/bram_port_responder.sv
// Single-port block-RAM responder for the NPU RAM port.
// Byte-lane writes, one or two register stages on the read path, selectable
// read-first / write-first return data, plus read-valid, address-error and
// saturating access-count sidebands.
// The array has no reset. Its configuration image is all zeros, which is the
// power-up content of an uninitialised block RAM.
module bram_port_responder #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rst_ram,
    input  logic               i_en_ram,
    input  logic [WIDTH/8-1:0] i_wr_ram,
    input  logic [31:0]        i_ram_addr,
    input  logic [WIDTH-1:0]   i_ram_data,
    output logic [WIDTH-1:0]   o_ram_data,
    output logic               o_rd_valid,
    output logic               o_addr_err,
    output logic [15:0]        o_rd_count,
    output logic [15:0]        o_wr_count
);

    localparam int NB = WIDTH / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Overlay the enabled byte lanes of new_w onto old_w.
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    logic [29:0]      word_idx;
    logic [AW-1:0]    mem_idx;
    logic             in_range;
    logic             is_write;
    logic             rd_req;
    logic             wr_commit;
    logic             rd_accept;
    logic             addr_lsb_unused;

    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic             err_p1;
    logic [15:0]      rd_cnt;
    logic [15:0]      wr_cnt;

    // Request decode: the address is a byte address, the array is word indexed.
    assign word_idx        = i_ram_addr[31:2];
    assign mem_idx         = word_idx[AW-1:0];
    assign in_range        = ({2'b00, word_idx} < 32'(DEPTH));
    assign is_write        = |i_wr_ram;
    assign rd_req          = i_en_ram & ~is_write & in_range;
    // Block reset swallows every request at its edge, writes included.
    assign wr_commit       = ~i_reset & i_en_ram & is_write & in_range;
    // Output-latch reset discards a read at the same edge, but not a write.
    assign rd_accept       = ~i_reset & ~i_rst_ram & rd_req;
    assign addr_lsb_unused = ^i_ram_addr[1:0];

    // Array write port with per-byte-lane enables.
    always_ff @(posedge i_clk) begin
        if (wr_commit) begin
            for (int k = 0; k < NB; k++) begin
                if (i_wr_ram[k]) begin
                    mem[mem_idx][8*k +: 8] <= i_ram_data[8*k +: 8];
                end
            end
        end
    end

    // ---- stage 1: output latch, loads only on enabled edges ----
    // Read-first returns the word as it was before this edge's write;
    // write-first returns the merged word the array is about to hold.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_rst_ram) begin
            data_p1 <= '0;
        end else if (i_en_ram) begin
            if (!in_range) begin
                data_p1 <= '0;
            end else if (is_write && (WRITE_FIRST != 0)) begin
                data_p1 <= merge_lanes(mem[mem_idx], i_ram_data, i_wr_ram);
            end else begin
                data_p1 <= mem[mem_idx];
            end
        end
    end

    // Stage 1 control: read-valid, address-error pulse and access counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else begin
            vld_p1 <= rd_accept;
            err_p1 <= i_en_ram & ~in_range;
            if (rd_accept) begin
                rd_cnt <= sat_inc(rd_cnt);
            end
            if (wr_commit) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end

    // ---- stage 2: optional extra register on the read path ----
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] data_p2;
            logic             vld_p2;

            // Copies stage 1 every edge; both resets clear it.
            always_ff @(posedge i_clk) begin
                if (i_reset || i_rst_ram) begin
                    data_p2 <= '0;
                    vld_p2  <= 1'b0;
                end else begin
                    data_p2 <= data_p1;
                    vld_p2  <= vld_p1;
                end
            end

            assign o_ram_data = data_p2;
            assign o_rd_valid = vld_p2;
        end else begin : g_lat1
            assign o_ram_data = data_p1;
            assign o_rd_valid = vld_p1;
        end
    endgenerate

    assign o_addr_err = err_p1;
    assign o_rd_count = rd_cnt;
    assign o_wr_count = wr_cnt;

endmodule
